mmc_spi_engine: RTL
===================

Name: mmc_spi_engine

Overview:
- SPI-mode byte engine that drives the SD/MMC card pins: mmc_cs, mmc_sclk, mmc_do and mmc_di.
- Sits between the disk/block controller and the card (mmc_model in simulation); one byte is exchanged per accepted command.
- SPI mode 0, MSB first, with a programmable SCLK divider.
- Supports CS-hold across multi-byte frames and CS-high dummy clocking for card initialisation.

Parameters:
DIV_W, 8, width of the divider input div.
IDLE_DO, 1, mmc_do level whenever no byte is shifting.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset_n  input  1  synchronous, active-low reset.
div  input  DIV_W  SCLK half-period minus one, in clk cycles; latched at command accept.
cmd_valid  input  1  command request.
cmd_ready  output  1  engine idle; a command is accepted when cmd_valid and cmd_ready are both high.
tx_byte  input  8  byte to shift out; latched at accept.
cmd_hold_cs  input  1  1 = leave CS asserted after this byte; 0 = release CS after the byte.
cmd_nocs  input  1  1 = clock the byte with CS high (dummy clocks); overrides cmd_hold_cs.
rx_byte  output  8  byte shifted in; valid from rx_valid onward, held until the next rx_valid.
rx_valid  output  1  one-cycle pulse at end of byte.
busy  output  1  inverse of cmd_ready.
crc_clear  input  1  clears the CRC7 accumulator.
crc7  output  7  running CRC7 of transmitted bits.
mmc_cs  output  1  card chip select, active low.
mmc_sclk  output  1  SPI clock; idle low.
mmc_do  output  1  data to card (MOSI).
mmc_di  input  1  data from card (MISO).

Behaviour:
- Reset values: mmc_cs=1, mmc_sclk=0, mmc_do=IDLE_DO, rx_byte=0x00, rx_valid=0, cmd_ready=1, crc7=0, state=IDLE.
- Reset mid-byte aborts the byte: no rx_valid, CS high on the cycle after the reset edge.
- State machine: IDLE -> SETUP -> (HIGH <-> LOW) x8 -> DONE -> IDLE.
- Half-period counter H = latched div+1 clk cycles; later changes to div do not affect a byte in flight.
- IDLE:
  - cmd_ready=1.
  - On accept: latch tx_byte, div, hold and nocs flags.
  - Next cycle: mmc_do=bit7, mmc_sclk=0, mmc_cs=0 unless nocs (then 1). Enter SETUP.
- SETUP: lasts H cycles, then sclk rises and the state becomes HIGH.
- HIGH:
  - mmc_di is registered into the shift register on the clk edge that drives sclk high.
  - Lasts H cycles, then sclk falls and the state becomes LOW.
  - On that falling edge mmc_do presents the next bit; after bit0 it presents IDLE_DO.
- LOW: lasts H cycles; after the 8th HIGH phase the closing LOW phase leads to DONE.
- DONE (1 cycle):
  - rx_valid=1, rx_byte updated, cmd_ready=1.
  - mmc_cs goes to 1 next cycle unless the hold flag was set and nocs was clear.
- Latency: rx_valid asserts exactly 17*H cycles after the accept edge.
- Back-to-back commands:
  - A command accepted in the DONE cycle starts SETUP next cycle.
  - With hold set, CS stays low continuously between the two bytes.
- CS timing: when released, CS goes high no earlier than H cycles after the last sclk fall; the LOW phase guarantees this.
- Width rules:
  - div=0 gives sclk = clk/2; div=255 gives clk/512.
  - The counter compares against the latched div and never wraps mid-phase.
- cmd_valid while busy is ignored: not latched and not queued.

Optional Feature:
- Macro MMC_SPI_CRC7_EN.
- Defined:
  - crc7 updates once per transmitted bit, at the same edge that shifts it out: polynomial x^7+x^3+1, shift-left, feedback = crc7[6]^bit.
  - crc_clear sets crc7=0. If crc_clear coincides with accept, the clear applies first and the new byte is included.
  - nocs bytes are excluded from the CRC.
- Undefined: crc7 is tied to 0 and crc_clear is ignored; ports remain.

Test Plan:
- Basic byte, loopback: reset, div=0, mmc_di looped to mmc_do, send 0xA5.
  - Expect rx_valid 17 cycles after accept, rx_byte=0xA5, 8 sclk rising edges, sclk period 2 clk.
  - Expect CS low for the transfer and high afterwards.
- Reset mid-byte: reset_n low during the 4th HIGH phase.
  - Expect next cycle mmc_cs=1, sclk=0, mmc_do=1, cmd_ready=1, no rx_valid pulse.
- Divider: div=3, send 0xFF with mmc_di held 0.
  - Expect sclk half-period 4 clk, rx_valid at 68 cycles, rx_byte=0x00.
  - Change div mid-byte and confirm the timing is unaffected.
- CMD0 frame: hold=1 on bytes 1-5 (0x40,0x00,0x00,0x00,0x00), issued back-to-back.
  - Expect CS low continuously across all five bytes, then released.
  - With MMC_SPI_CRC7_EN: crc7=0x4A, i.e. CRC byte 0x95.
- Dummy clocks: ten bytes 0xFF with nocs=1, hold=1.
  - Expect 80 sclk pulses, CS never low, and the crc7 value unchanged from before the dummy bytes.
- Busy handling: assert cmd_valid with 0x12 while busy, then keep it asserted through DONE.
  - Expect no effect while busy; accept in the DONE cycle; SETUP starts the following cycle.

Source files
------------

// File: rtl/mmc_spi_engine_if.sv
// Host/card-side signal bundle for mmc_spi_engine.
// The engine takes the slave modport; the host (and card model) takes master.
interface mmc_spi_engine_if #(
    parameter int DIV_W = 8
);
    // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
    // cmd_ready is high only when the engine is idle or finishing a byte; cmd_valid
    // presented while cmd_ready is low is neither latched nor queued.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       tx_byte;
    logic             cmd_hold_cs;
    logic             cmd_nocs;
    logic [DIV_W-1:0] div;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             busy;
    logic             crc_clear;
    logic [6:0]       crc7;
    logic             mmc_cs;
    logic             mmc_sclk;
    logic             mmc_do;
    logic             mmc_di;

    modport master (
        output cmd_valid, tx_byte, cmd_hold_cs, cmd_nocs, div, crc_clear, mmc_di,
        input  cmd_ready, rx_byte, rx_valid, busy, crc7, mmc_cs, mmc_sclk, mmc_do
    );

    modport slave (
        input  cmd_valid, tx_byte, cmd_hold_cs, cmd_nocs, div, crc_clear, mmc_di,
        output cmd_ready, rx_byte, rx_valid, busy, crc7, mmc_cs, mmc_sclk, mmc_do
    );
endinterface

// File: rtl/mmc_spi_engine.sv
// SPI mode-0, MSB-first byte engine for SD/MMC cards with programmable SCLK divider.
// Defining MMC_SPI_CRC7_EN enables a running CRC7 over transmitted (non-dummy) bits.
module mmc_spi_engine #(
    parameter int DIV_W   = 8,
    parameter bit IDLE_DO = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mmc_spi_engine_if.slave        bus,
    output logic [2:0]             state_o
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d, rx_byte_q, rx_byte_d;
    logic [2:0]       bit_q, bit_d;
    logic             hold_q, hold_d, nocs_q, nocs_d;
    logic             cs_q, cs_d, sclk_q, sclk_d, do_q, do_d;
    logic             rx_valid_q, rx_valid_d;
    logic [6:0]       crc_q, crc_d;
    logic             ready, accept, phase_end, shift_en, shift_bit;

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign accept    = bus.cmd_valid && ready;
    assign phase_end = (cnt_q == div_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_byte_d  = rx_byte_q;
        bit_d      = bit_q;
        hold_d     = hold_q;
        nocs_d     = nocs_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        do_d       = do_q;
        rx_valid_d = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                    cs_d    = !(hold_q && !nocs_q);
                end
                // A command taken in DONE starts immediately; CS is re-driven so a held frame never blips.
                if (accept) begin
                    state_d   = SETUP;
                    div_d     = bus.div;
                    tx_d      = {bus.tx_byte[6:0], 1'b0};
                    rx_d      = '0;
                    hold_d    = bus.cmd_hold_cs;
                    nocs_d    = bus.cmd_nocs;
                    cnt_d     = '0;
                    bit_d     = '0;
                    do_d      = bus.tx_byte[7];
                    sclk_d    = 1'b0;
                    cs_d      = bus.cmd_nocs;
                    shift_en  = !bus.cmd_nocs;
                    shift_bit = bus.tx_byte[7];
                end
            end
            SETUP: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_ONE;
                if (phase_end) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], bus.mmc_di};
                end
            end
            HIGH: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_ONE;
                if (phase_end) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    if (bit_q == 3'd7) begin
                        do_d = IDLE_DO;
                    end else begin
                        do_d      = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        shift_en  = !nocs_q;
                        shift_bit = tx_q[7];
                    end
                end
            end
            LOW: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_ONE;
                if (phase_end) begin
                    if (bit_q == 3'd7) begin
                        state_d    = DONE;
                        rx_valid_d = 1'b1;
                        rx_byte_d  = rx_q;
                    end else begin
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + 3'd1;
                        rx_d    = {rx_q[6:0], bus.mmc_di};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MMC_SPI_CRC7_EN
    logic [6:0] crc_base;
    // Clear takes effect before the bit shifted on the same edge, so a cleared accept counts its byte.
    always_comb begin
        crc_base = bus.crc_clear ? 7'h00 : crc_q;
        crc_d    = crc_base;
        if (shift_en) begin
            crc_d = {crc_base[5:0], 1'b0} ^ ((crc_base[6] ^ shift_bit) ? 7'h09 : 7'h00);
        end
    end
`else
    logic unused_crc;
    assign unused_crc = ^{bus.crc_clear, shift_en, shift_bit};
    assign crc_d      = 7'h00;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_byte_q  <= '0;
            bit_q      <= '0;
            hold_q     <= 1'b0;
            nocs_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            do_q       <= IDLE_DO;
            rx_valid_q <= 1'b0;
            crc_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_byte_q  <= rx_byte_d;
            bit_q      <= bit_d;
            hold_q     <= hold_d;
            nocs_q     <= nocs_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            do_q       <= do_d;
            rx_valid_q <= rx_valid_d;
            crc_q      <= crc_d;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.busy      = !ready;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.crc7      = crc_q;
    assign bus.mmc_cs    = cs_q;
    assign bus.mmc_sclk  = sclk_q;
    assign bus.mmc_do    = do_q;
    assign state_o       = state_q;
endmodule
